clock_set_controller: RTL and testbench
=======================================

Name: clock_set_controller

Overview:
- Time-adjust sequencer for the 24-hour BCD clock counter.
- Debounces three push-buttons and freezes the counter while the user edits hours, minutes and seconds in a shadow copy.
- Writes the edited time back with a one-cycle load strobe and drives a blink mask so the display scanner can flash the field being edited.
- Sits between the board buttons and the clock counter / seven-segment scan logic.

Parameters:
- DEBOUNCE, 1000000: consecutive stable clk cycles required to accept a button level change (10 ms at 100 MHz).
- BLINK_DIV, 50000000: clk cycles per blink half-period (0.5 s at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz.
- init  in  1  asynchronous, active-low reset.
- btn_mode  in  1  raw mode button, active-high, asynchronous to clk.
- btn_inc  in  1  raw increment button, active-high, asynchronous.
- btn_dec  in  1  raw decrement button, active-high, asynchronous.
- cur_time  in  24  live counter value {hon_h,hon_l,min_h,min_l,sec_h,sec_l}, 4-bit BCD each.
- stay  out  1  counter hold; 1 freezes counting.
- load  out  1  one-cycle strobe: counter takes load_time.
- load_time  out  24  shadow time, same digit order as cur_time.
- blink_mask  out  6  1 = blank that digit; bit5 = hon_h … bit0 = sec_l.
- mode  out  2  current state encoding.

Behaviour:
- Reset (init=0, async): state RUN, stay=0, load=0, load_time=0, blink_mask=0, mode=0, shadow=0. Synchronisers, debouncers and blink counter clear. Reset applied mid-edit abandons the edit; no load is issued.
- Button path, per button:
  - 2-FF synchroniser, then debouncer. The stable level updates after DEBOUNCE consecutive cycles of a differing synchronised level; any bounce restarts the count.
  - A rising edge of the stable level gives a 1-cycle press pulse, DEBOUNCE+3 clk edges after raw goes high.
  - Release produces no pulse.
- States and encoding: RUN=0, SET_H=1, SET_M=2, SET_S=3. A mode press advances RUN→SET_H→SET_M→SET_S→RUN.
- RUN→SET_H: shadow <= cur_time in the same cycle. stay=1 from the next cycle.
- SET_*: stay=1. load_time always reflects the shadow.
- SET_S→RUN on mode press:
  - load=1 for exactly that one cycle, with load_time = shadow; stay is still 1 in that cycle.
  - Next cycle: state RUN, stay=0, load=0.
- inc/dec act on the selected field only, as a 2-digit BCD value with wrap:
  - Hours: 00..23. 23+1→00; 00-1→23.
  - Minutes and seconds: 00..59. 59+1→00; 00-1→59.
  - Units digit carries/borrows into the tens digit (09+1→10, 10-1→09).
  - Invalid captured field (value > max or a digit > 9): inc gives 00, dec gives max.
- Simultaneous events, same cycle:
  - inc+dec: both ignored.
  - mode with inc/dec: mode wins, inc/dec dropped.
  - inc/dec in RUN: ignored.
- Blink:
  - Counter restarts and phase=0 on every state change and on every accepted inc/dec.
  - Phase toggles every BLINK_DIV cycles.
  - blink_mask has the two bits of the selected field set when phase=1, all other bits 0. In RUN, blink_mask=0.
- All outputs are registered.

Decomposition:
- Shared header clock_defs.vh holds:
  - state encodings RUN/SET_H/SET_M/SET_S;
  - field limits HOUR_MAX=8'h23 and MINSEC_MAX=8'h59;
  - digit index constants for the 24-bit time bus.
- Sub-module btn_debounce (synchroniser + debouncer + rising-edge pulse; parameter DEBOUNCE), instantiated three times.
- BCD inc/dec is a function inside clock_set_controller.

Test Plan:
All scenarios use DEBOUNCE=4, BLINK_DIV=8.
1. Reset, then a clean btn_mode press, with cur_time=24'h123456 → pulse at edge 7; shadow/load_time=24'h123456, mode=1, stay=1, blink_mask toggles 6'b000000/6'b110000 every 8 cycles.
2. In SET_H, shadow hours=23, one inc → hours 00; then two dec → 22. Blink phase restarts to 0 after each press.
3. Walk to SET_M with minutes=09 and inc → 10. SET_S with seconds=00 and dec → 59. Then mode → load=1 for exactly 1 cycle with load_time={hours,10,59}; the next cycle shows mode=0, stay=0.
4. Bouncing btn_inc (high 2, low 1, high 6 cycles) → exactly one inc pulse. inc and dec pulses in the same cycle → shadow unchanged.
5. Assert init low while in SET_M after edits → all outputs 0 immediately, asynchronously. No load pulse after release; mode=0.
6. Capture cur_time with hours=8'h3A, then inc in SET_H → 00; a fresh capture plus dec → 23.

Source files
------------

// File: rtl/clock_set_controller_pkg.sv
// Shared encodings, field limits and time-bus digit positions for the
// clock time-adjust sequencer.
package clock_set_controller_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    // LSB of each 2-digit field on {hon_h,hon_l,min_h,min_l,sec_h,sec_l}
    localparam int HOUR_LSB = 16;
    localparam int MIN_LSB  = 8;
    localparam int SEC_LSB  = 0;

    localparam int NUM_BTN = 3;

    typedef struct packed {
        logic dec;
        logic inc;
        logic mode;
    } btn_evt_t;

    function automatic logic [5:0] field_mask(input state_t s);
        case (s)
            SET_H:   return 6'b110000;
            SET_M:   return 6'b001100;
            SET_S:   return 6'b000011;
            default: return 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/clock_set_controller_btn_debounce.sv
// One push-button path: 2-FF synchroniser, level debouncer and a registered
// one-cycle pulse on each accepted rising edge.
module btn_debounce #(
    parameter int DEBOUNCE = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [1:0]    sync;
    logic          stable;
    logic          stable_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= '0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
            pulse    <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            // any sample matching the accepted level restarts the count
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE - 1)) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            stable_q <= stable;
            pulse    <= stable & ~stable_q;
        end
    end

endmodule

// File: rtl/clock_set_controller.sv
// Time-adjust sequencer: edits a shadow copy of the BCD time while the
// counter is held, writes it back with a load strobe, and blinks the field.
module clock_set_controller
    import clock_set_controller_pkg::*;
#(
    parameter int DEBOUNCE  = 1000000,
    parameter int BLINK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        init,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [23:0] cur_time,
    output logic        stay,
    output logic        load,
    output logic [23:0] load_time,
    output logic [5:0]  blink_mask,
    output logic [1:0]  mode
);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // 2-digit BCD step with wrap; out-of-range input snaps to 00 / max
    function automatic logic [7:0] bcd_step(input logic [7:0] v,
                                            input logic [7:0] vmax,
                                            input logic       up);
        logic ok;
        ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= vmax);
        if (!ok)                return up ? 8'h00 : vmax;
        if (up) begin
            if (v == vmax)          return 8'h00;
            if (v[3:0] == 4'd9)     return {v[7:4] + 4'd1, 4'd0};
            return {v[7:4], v[3:0] + 4'd1};
        end
        if (v == 8'h00)             return vmax;
        if (v[3:0] == 4'd0)         return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    logic [NUM_BTN-1:0] btn_raw, btn_pulse;
    btn_evt_t           evt;

    assign btn_raw = {btn_dec, btn_inc, btn_mode};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk   (clk),
            .rst_n (init),
            .raw   (btn_raw[i]),
            .pulse (btn_pulse[i])
        );
    end

    assign evt = btn_evt_t'(btn_pulse);

    state_t        state, state_nx;
    logic [23:0]   shadow, shadow_nx;
    logic          load_nx, stay_nx, adj;
    logic [7:0]    fld, fmax, fld_nx;
    logic [BW-1:0] blink_cnt, blink_cnt_nx;
    logic          phase, phase_nx;
    logic [5:0]    mask_nx;

    always_comb begin
        state_nx     = state;
        shadow_nx    = shadow;
        load_nx      = 1'b0;
        adj          = 1'b0;
        fld          = 8'h00;
        fmax         = MINSEC_MAX;
        blink_cnt_nx = blink_cnt;
        phase_nx     = phase;

        case (state)
            SET_H:   begin fld = shadow[HOUR_LSB +: 8]; fmax = HOUR_MAX; end
            SET_M:   fld = shadow[MIN_LSB +: 8];
            SET_S:   fld = shadow[SEC_LSB +: 8];
            default: ;
        endcase
        fld_nx = bcd_step(fld, fmax, evt.inc);

        // the load cycle stays in SET_S so mode reads 3 alongside the strobe
        if (load) begin
            state_nx = RUN;
        end else if (evt.mode) begin
            case (state)
                RUN:     begin state_nx = SET_H; shadow_nx = cur_time; end
                SET_H:   state_nx = SET_M;
                SET_M:   state_nx = SET_S;
                default: load_nx = 1'b1;
            endcase
        end else if ((state != RUN) && (evt.inc ^ evt.dec)) begin
            adj = 1'b1;
            case (state)
                SET_H:   shadow_nx[HOUR_LSB +: 8] = fld_nx;
                SET_M:   shadow_nx[MIN_LSB +: 8]  = fld_nx;
                default: shadow_nx[SEC_LSB +: 8]  = fld_nx;
            endcase
        end

        stay_nx = (state_nx != RUN) || load_nx;

        if ((state_nx != state) || adj) begin
            blink_cnt_nx = '0;
            phase_nx     = 1'b0;
        end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt_nx = '0;
            phase_nx     = ~phase;
        end else begin
            blink_cnt_nx = blink_cnt + BW'(1);
        end

        mask_nx = phase_nx ? field_mask(state_nx) : 6'b000000;
    end

    always_ff @(posedge clk or negedge init) begin
        if (!init) begin
            state      <= RUN;
            shadow     <= '0;
            load       <= 1'b0;
            stay       <= 1'b0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            blink_mask <= '0;
        end else begin
            state      <= state_nx;
            shadow     <= shadow_nx;
            load       <= load_nx;
            stay       <= stay_nx;
            blink_cnt  <= blink_cnt_nx;
            phase      <= phase_nx;
            blink_mask <= mask_nx;
        end
    end

    assign mode      = state;
    assign load_time = shadow;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with short debounce and blink periods.
module tb_clock_set_controller;

    logic        clk = 1'b0;
    logic        init;
    logic        btn_mode, btn_inc, btn_dec;
    logic [23:0] cur_time;
    logic        stay, load;
    logic [23:0] load_time;
    logic [5:0]  blink_mask;
    logic [1:0]  mode;

    int checks = 0;
    int errors = 0;
    int load_cnt = 0;
    int load_base;

    clock_set_controller #(.DEBOUNCE(4), .BLINK_DIV(8)) dut (
        .clk        (clk),
        .init       (init),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .cur_time   (cur_time),
        .stay       (stay),
        .load       (load),
        .load_time  (load_time),
        .blink_mask (blink_mask),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load === 1'b1) load_cnt++;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // idle so any prior release settles, hold 8 cycles; the action is
    // registered on the 8th edge after the raw rise
    task automatic press(input logic m, input logic i, input logic d);
        repeat (8) @(negedge clk);
        btn_mode = m; btn_inc = i; btn_dec = d;
        repeat (8) @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);
        init = 1'b1;
    endtask

    initial begin
        init = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        cur_time = 24'h123456;
        repeat (2) @(negedge clk);
        chk("rst_mode", {22'd0, mode}, 24'd0);
        chk("rst_stay", {23'd0, stay}, 24'd0);
        chk("rst_load", {23'd0, load}, 24'd0);
        chk("rst_load_time", load_time, 24'd0);
        chk("rst_blink", {18'd0, blink_mask}, 24'd0);
        init = 1'b1;

        // clean mode press captures the live time
        press(1'b1, 1'b0, 1'b0);
        chk("s1_mode", {22'd0, mode}, 24'd1);
        chk("s1_stay", {23'd0, stay}, 24'd1);
        chk("s1_load_time", load_time, 24'h123456);
        chk("s1_blink0", {18'd0, blink_mask}, 24'd0);
        repeat (7) @(negedge clk);
        chk("s1_blink7", {18'd0, blink_mask}, 24'd0);
        @(negedge clk);
        chk("s1_blink8", {18'd0, blink_mask}, 24'h30);
        repeat (8) @(negedge clk);
        chk("s1_blink16", {18'd0, blink_mask}, 24'd0);

        // hour wrap, then minute carry and second borrow, then write-back
        cur_time = 24'h230900;
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        chk("s2_capture", load_time, 24'h230900);
        press(1'b0, 1'b1, 1'b0);
        chk("s2_inc23", load_time, 24'h000900);
        chk("s2_blink_restart", {18'd0, blink_mask}, 24'd0);
        repeat (8) @(negedge clk);
        chk("s2_blink_on", {18'd0, blink_mask}, 24'h30);
        press(1'b0, 1'b0, 1'b1);
        chk("s2_dec00", load_time, 24'h230900);
        chk("s2_blink_restart2", {18'd0, blink_mask}, 24'd0);
        press(1'b0, 1'b0, 1'b1);
        chk("s2_dec23", load_time, 24'h220900);
        press(1'b1, 1'b0, 1'b0);
        chk("s3_mode_m", {22'd0, mode}, 24'd2);
        repeat (8) @(negedge clk);
        chk("s3_blink_m", {18'd0, blink_mask}, 24'h0C);
        press(1'b0, 1'b1, 1'b0);
        chk("s3_inc09", load_time, 24'h221000);
        press(1'b1, 1'b0, 1'b0);
        chk("s3_mode_s", {22'd0, mode}, 24'd3);
        press(1'b0, 1'b0, 1'b1);
        chk("s3_dec00", load_time, 24'h221059);
        repeat (8) @(negedge clk);
        chk("s3_blink_s", {18'd0, blink_mask}, 24'h03);
        load_base = load_cnt;
        press(1'b1, 1'b0, 1'b0);
        chk("s3_load", {23'd0, load}, 24'd1);
        chk("s3_load_stay", {23'd0, stay}, 24'd1);
        chk("s3_load_time", load_time, 24'h221059);
        @(negedge clk);
        chk("s3_post_load", {23'd0, load}, 24'd0);
        chk("s3_post_mode", {22'd0, mode}, 24'd0);
        chk("s3_post_stay", {23'd0, stay}, 24'd0);
        repeat (10) @(negedge clk);
        chk("s3_load_count", 24'(load_cnt - load_base), 24'd1);

        // inc in RUN ignored; bouncing inc gives one step; combined presses
        cur_time = 24'h104530;
        do_reset();
        press(1'b0, 1'b1, 1'b0);
        chk("s4_run_inc_mode", {22'd0, mode}, 24'd0);
        chk("s4_run_inc_time", load_time, 24'd0);
        press(1'b1, 1'b0, 1'b0);
        chk("s4_capture", load_time, 24'h104530);
        repeat (8) @(negedge clk);
        btn_inc = 1'b1;
        repeat (2) @(negedge clk);
        btn_inc = 1'b0;
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (6) @(negedge clk);
        btn_inc = 1'b0;
        repeat (12) @(negedge clk);
        chk("s4_bounce", load_time, 24'h114530);
        press(1'b0, 1'b1, 1'b1);
        chk("s4_inc_dec", load_time, 24'h114530);
        chk("s4_inc_dec_mode", {22'd0, mode}, 24'd1);
        press(1'b1, 1'b1, 1'b0);
        chk("s4_mode_wins", {22'd0, mode}, 24'd2);
        chk("s4_mode_wins_time", load_time, 24'h114530);
        press(1'b0, 1'b1, 1'b0);
        chk("s4_min_inc", load_time, 24'h114630);

        // async reset mid-edit abandons the edit
        load_base = load_cnt;
        @(negedge clk);
        #2 init = 1'b0;
        #1;
        chk("s5_mode", {22'd0, mode}, 24'd0);
        chk("s5_stay", {23'd0, stay}, 24'd0);
        chk("s5_load", {23'd0, load}, 24'd0);
        chk("s5_load_time", load_time, 24'd0);
        chk("s5_blink", {18'd0, blink_mask}, 24'd0);
        @(negedge clk);
        init = 1'b1;
        repeat (20) @(negedge clk);
        chk("s5_no_load", 24'(load_cnt - load_base), 24'd0);
        chk("s5_mode_after", {22'd0, mode}, 24'd0);

        // invalid captured hours
        cur_time = 24'h3A0000;
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        chk("s6_capture", load_time, 24'h3A0000);
        press(1'b0, 1'b1, 1'b0);
        chk("s6_inc_invalid", load_time, 24'h000000);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("s6_back_run", {22'd0, mode}, 24'd0);
        press(1'b1, 1'b0, 1'b0);
        chk("s6_recapture", load_time, 24'h3A0000);
        press(1'b0, 1'b0, 1'b1);
        chk("s6_dec_invalid", load_time, 24'h230000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
